// File: rtl/wb_trace_fifo_pkg.sv
// Shared widths, defaults and entry-layout helpers for the write-back trace capture unit.
package wb_trace_fifo_pkg;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned AW_DEFAULT    = 5;
    localparam int unsigned DW_DEFAULT    = 32;
    localparam int unsigned SW_DEFAULT    = 16;
    localparam int unsigned DROP_W        = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Packed entry layout, MSB to LSB: {seq, addr, data}
    function automatic int unsigned entry_width(input int unsigned sw,
                                                input int unsigned aw,
                                                input int unsigned dw);
        return sw + aw + dw;
    endfunction

    function automatic int unsigned data_lsb();
        return 0;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned seq_lsb(input int unsigned aw,
                                            input int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/wb_trace_fifo_sync_fifo.sv
// Single-clock FIFO with async reset; accepts a push while full when a pop happens the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    prev_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign prev_ptr = rd_ptr - PW'(1);

    // When empty, the slot behind rd_ptr still holds the last popped entry and
    // cannot be overwritten until a push makes the FIFO non-empty again.
    assign rd_data = empty ? mem[prev_ptr] : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures non-zero register write-backs with a sequence number and streams them out via valid/ready.
module wb_trace_fifo
    import wb_trace_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned SW    = SW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [AW-1:0] trace_addr,
    output logic [DW-1:0] trace_data,
    output logic [SW-1:0] trace_seq,
    output logic [7:0]    drop_count,
    output logic          overflow
);

    localparam int unsigned EW   = entry_width(SW, AW, DW);
    localparam int unsigned D_LO = data_lsb();
    localparam int unsigned A_LO = addr_lsb(DW);
    localparam int unsigned S_LO = seq_lsb(AW, DW);

    logic          capture;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    logic [SW-1:0] seq_ctr;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] entry_out;

    assign capture  = wb_en && (wb_addr != '0);
    assign pop      = trace_valid && trace_ready;
    assign drop     = capture && full && !pop;
    assign entry_in = {seq_ctr, wb_addr, wb_data};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (capture),
        .pop     (pop),
        .wr_data (entry_in),
        .rd_data (entry_out),
        .full    (full),
        .empty   (empty)
    );

    assign trace_valid = !empty;
    assign trace_data  = entry_out[D_LO +: DW];
    assign trace_addr  = entry_out[A_LO +: AW];
    assign trace_seq   = entry_out[S_LO +: SW];

    // Dropped captures still consume a number so consumers can see the gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_ctr <= '0;
        end else if (capture) begin
            seq_ctr <= seq_ctr + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule
